// File: rtl/nn_mem_pkg.sv
// Shared constants and state encoding for the NN input/weight memory
// loader and reader.
package nn_mem_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 10;
    localparam int IMG_DEPTH = 784;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FIN
    } state_t;

endpackage

// File: rtl/bram_stream_loader_if.sv
// Valid/ready byte stream between the host byte source and the loader.
interface bram_stream_loader_if
    import nn_mem_pkg::*;
#(
    parameter int DW = DATA_W
);

    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/bram_stream_loader.sv
// Writes one frame of stream bytes into BRAM port A at addresses 0..DEPTH-1
// and pulses done when the frame is stored.
module bram_stream_loader
    import nn_mem_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int AW    = ADDR_W,
    parameter int DEPTH = IMG_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    bram_stream_loader_if.slave  s,
    output logic                 wea,
    output logic [AW-1:0]        addra,
    output logic [DW-1:0]        dina,
    output logic                 busy,
    output logic                 done,
    output logic [AW:0]          count,
    output logic                 err_short,
    output logic                 err_nolast
);

    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    state_t        state_q, state_d;
    logic          wea_q, wea_d;
    logic [AW-1:0] addra_q, addra_d;
    logic [DW-1:0] dina_q, dina_d;
    logic [AW:0]   count_q, count_d;
    logic          done_q, done_d;
    logic          err_short_q, err_short_d;
    logic          err_nolast_q, err_nolast_d;

    logic ready;
    logic accept;

    assign ready     = (state_q == S_LOAD);
    assign accept    = s.s_valid && ready;
    assign s.s_ready = ready;

    always_comb begin
        state_d      = state_q;
        wea_d        = 1'b0;
        addra_d      = addra_q;
        dina_d       = dina_q;
        count_d      = count_q;
        done_d       = 1'b0;
        err_short_d  = err_short_q;
        err_nolast_d = err_nolast_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d      = S_LOAD;
                    count_d      = '0;
                    err_short_d  = 1'b0;
                    err_nolast_d = 1'b0;
                end
            end
            S_LOAD: begin
                // abort beats a same-cycle accept: nothing is written
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    wea_d   = 1'b1;
                    addra_d = count_q[AW-1:0];
                    dina_d  = s.s_data;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        if (!s.s_last) begin
                            err_nolast_d = 1'b1;
                        end
                    end else if (s.s_last) begin
                        state_d     = S_FIN;
                        done_d      = 1'b1;
                        err_short_d = 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wea_q        <= 1'b0;
            addra_q      <= '0;
            dina_q       <= '0;
            count_q      <= '0;
            done_q       <= 1'b0;
            err_short_q  <= 1'b0;
            err_nolast_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wea_q        <= wea_d;
            addra_q      <= addra_d;
            dina_q       <= dina_d;
            count_q      <= count_d;
            done_q       <= done_d;
            err_short_q  <= err_short_d;
            err_nolast_q <= err_nolast_d;
        end
    end

    assign wea        = wea_q;
    assign addra      = addra_q;
    assign dina       = dina_q;
    assign busy       = (state_q == S_LOAD);
    assign done       = done_q;
    assign count      = count_q;
    assign err_short  = err_short_q;
    assign err_nolast = err_nolast_q;

endmodule

// File: tb/tb_bram_stream_loader.sv
// Directed bench for bram_stream_loader with a write scoreboard.
module tb_bram_stream_loader;

    localparam int DEPTH = 784;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        wea;
    logic [9:0]  addra;
    logic [7:0]  dina;
    logic        busy;
    logic        done;
    logic [10:0] count;
    logic        err_short;
    logic        err_nolast;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int done_ref;

    logic [17:0] exp_q[$];
    logic [7:0]  mem[DEPTH];

    bram_stream_loader_if bus ();

    bram_stream_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .s          (bus),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .err_short  (err_short),
        .err_nolast (err_nolast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every BRAM write must match the oldest pending beat
    always @(negedge clk) begin
        logic [17:0] e;
        if (done === 1'b1) done_cnt++;
        if (wea === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL unexp_wr observed addr=%0d expected none",
                       addra);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(addra), 32'(e[17:8]));
                chk("wr_data", 32'(dina), 32'(e[7:0]));
                if (addra < 10'(DEPTH)) mem[addra] = dina;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hxx;
    endtask

    task automatic check_mem(input string tag);
        int bad;
        logic [31:0] iv;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            iv = 32'(i);
            if (mem[i] !== iv[7:0]) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(bus.s_ready), 32'd1);
        chk("start_count", 32'(count), 32'd0);
    endtask

    // ends at the negedge one cycle after the last driven beat
    task automatic run_frame(input int n, input int last_idx,
                             input bit gap, input int abort_idx,
                             input int rst_idx);
        logic [31:0] iv;
        for (int i = 0; i < n; i++) begin
            iv = 32'(i);
            if (gap) begin
                @(negedge clk);
                bus.s_valid = 1'b0;
            end
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = iv[7:0];
            bus.s_last  = (i == last_idx);
            if (i == abort_idx) begin
                abort = 1'b1;
                break;
            end
            if (i == rst_idx) begin
                rst = 1'b1;
                break;
            end
            exp_q.push_back({iv[9:0], iv[7:0]});
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        abort       = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic check_fin(input string tag, input int n,
                             input bit es, input bit en);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_wea"}, 32'(wea), 32'd1);
        chk({tag, "_addr"}, 32'(addra), 32'(n - 1));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(bus.s_ready), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'(n));
        chk({tag, "_eshort"}, 32'(err_short), 32'(es));
        chk({tag, "_enolast"}, 32'(err_nolast), 32'(en));
        @(negedge clk);
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_wea_off"}, 32'(wea), 32'd0);
        chk({tag, "_ready_off"}, 32'(bus.s_ready), 32'd0);
        chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(bus.s_ready), 32'd0);
        chk({tag, "_wea"}, 32'(wea), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_eshort"}, 32'(err_short), 32'd0);
        chk({tag, "_enolast"}, 32'(err_nolast), 32'd0);
        chk({tag, "_addra"}, 32'(addra), 32'd0);
        chk({tag, "_dina"}, 32'(dina), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");

        // full frame, back-to-back beats
        do_start();
        run_frame(DEPTH, DEPTH - 1, 1'b0, -1, -1);
        check_fin("full", DEPTH, 1'b0, 1'b0);
        chk("full_done_cnt", 32'(done_cnt), 32'd1);
        check_mem("full_mem");

        // same frame, s_valid toggled every other cycle
        clear_mem();
        do_start();
        run_frame(DEPTH, DEPTH - 1, 1'b1, -1, -1);
        check_fin("gap", DEPTH, 1'b0, 1'b0);
        chk("gap_done_cnt", 32'(done_cnt), 32'd2);
        check_mem("gap_mem");

        // early s_last on beat 10
        do_start();
        run_frame(11, 10, 1'b0, -1, -1);
        check_fin("short", 11, 1'b1, 1'b0);
        chk("short_done_cnt", 32'(done_cnt), 32'd3);

        // full frame without s_last
        do_start();
        chk("nolast_eshort_clr", 32'(err_short), 32'd0);
        run_frame(DEPTH, -1, 1'b0, -1, -1);
        check_fin("nolast", DEPTH, 1'b0, 1'b1);
        chk("nolast_done_cnt", 32'(done_cnt), 32'd4);

        // start with abort in IDLE stays idle, errors kept
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_enolast", 32'(err_nolast), 32'd1);

        // abort on beat 300 together with a valid beat
        do_start();
        chk("abort_enolast_clr", 32'(err_nolast), 32'd0);
        done_ref = done_cnt;
        run_frame(DEPTH, -1, 1'b0, 300, -1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wea", 32'(wea), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_count", 32'(count), 32'd300);
        chk("abort_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(done_ref));

        // reset on beat 500
        do_start();
        run_frame(DEPTH, -1, 1'b0, -1, 500);
        check_reset_vals("midrst");
        chk("midrst_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'(done_ref));
        chk("midrst_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
